// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash READ responder: opcodes, FSM states
// and the default JEDEC identification value.
package spi_flash_pkg;

  localparam logic [7:0]  OP_READ          = 8'h03;
  localparam logic [7:0]  OP_RDID          = 8'h9F;
  localparam logic [23:0] JEDEC_ID_DEFAULT = 24'hEF4016;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    FETCH,
    DATA,
    IGNORE
  } state_e;

endpackage

// File: rtl/spi_pin_sync.sv
// Brings sclk/cs/mosi into the clk domain through SYNC_STAGES flops and
// derives single-cycle edge strobes from the last two synchronized samples.
// cs resets to its idle (high) level so reset never fakes a cs_fall.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  // pin order: [2]=sclk, [1]=cs, [0]=mosi
  localparam logic [2:0] PIN_RST = 3'b010;

  logic [2:0] pin_in;
  logic [2:0] pin_s;
  logic [1:0] prev_q, prev_d;

  assign pin_in = {sclk, cs, mosi};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_pin
      logic [SYNC_STAGES-1:0] chain_q, chain_d;

      // shift the raw pin into the synchronizer chain
      always_comb chain_d = {chain_q[SYNC_STAGES-2:0], pin_in[gi]};

      // synchronizer flops
      always_ff @(posedge clk) begin
        if (!reset) chain_q <= {SYNC_STAGES{PIN_RST[gi]}};
        else        chain_q <= chain_d;
      end

      assign pin_s[gi] = chain_q[SYNC_STAGES-1];
    end
  endgenerate

  // remember the previous synchronized sclk/cs for edge detection
  always_comb prev_d = pin_s[2:1];

  // previous-sample register
  always_ff @(posedge clk) begin
    if (!reset) prev_q <= PIN_RST[2:1];
    else        prev_q <= prev_d;
  end

  assign sclk_rise = pin_s[2] & ~prev_q[1];
  assign sclk_fall = ~pin_s[2] & prev_q[1];
  assign cs_fall   = ~pin_s[1] & prev_q[0];
  assign cs_rise   = pin_s[1] & ~prev_q[0];
  assign mosi_s    = pin_s[0];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash stand-in answering READ (0x03): 24-bit byte address,
// then 32-bit words streamed MSB-first from a synchronous memory port with
// a mid-word prefetch so consecutive words leave no gap.
// Optional macro SPI_FLASH_RESPONDER_READ_ID_EN enables RDID (0x9F).
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int SYNC_STAGES = 2
`ifdef SPI_FLASH_RESPONDER_READ_ID_EN
  ,
  parameter logic [23:0] JEDEC_ID = JEDEC_ID_DEFAULT
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  // wide enough for the opcode and for address bits [ADDR_W+1:2]
  localparam int SH_W = (ADDR_W + 1 > 7) ? ADDR_W + 1 : 7;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .mosi_s    (mosi_s)
  );

  state_e            state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [SH_W-1:0]   shift_q, shift_d;
  logic [31:0]       tx_q, tx_d;
  logic [31:0]       next_q, next_d;
  logic              mem_en_q, mem_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rd_valid_q, rd_valid_d;
  logic              miso_q, miso_d;
  logic              miso_oe_q, miso_oe_d;
  logic              busy_q, busy_d;
  logic              cmd_err_q, cmd_err_d;
  logic              rdid_q, rdid_d;
  logic [7:0]        opcode;

  assign opcode = {shift_q[6:0], mosi_s};

  // next-state and datapath decisions; cs_rise overrides everything
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    next_d     = next_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    rd_valid_d = mem_en_q;            // read data lands one clk after mem_en
    miso_d     = miso_q;
    miso_oe_d  = miso_oe_q;
    busy_d     = busy_q;
    cmd_err_d  = cmd_err_q;
    rdid_d     = rdid_q;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = CMD;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
        end
      end
      CMD: begin
        if (sclk_rise) begin
          shift_d   = {shift_q[SH_W-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            if (opcode == OP_READ) begin
              state_d = ADDR;
            end
`ifdef SPI_FLASH_RESPONDER_READ_ID_EN
            else if (opcode == OP_RDID) begin
              state_d   = DATA;
              rdid_d    = 1'b1;
              tx_d      = {8'h00, JEDEC_ID};
              miso_oe_d = 1'b1;
            end
`endif
            else begin
              cmd_err_d = 1'b1;
              state_d   = IGNORE;
            end
          end
        end
      end
      ADDR: begin
        if (sclk_rise) begin
          shift_d   = {shift_q[SH_W-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            // byte address bits [1:0] are dropped: shift_q[k] holds addr24[k+1]
            bit_cnt_d  = '0;
            mem_en_d   = 1'b1;
            mem_addr_d = shift_q[ADDR_W:1];
            state_d    = FETCH;
          end
        end
      end
      FETCH: begin
        if (rd_valid_q) begin
          tx_d      = mem_rdata;
          miso_oe_d = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (rdid_q) begin
          // rotate the 24-bit ID so it repeats for as long as cs stays low
          if (sclk_fall) begin
            miso_d = tx_q[23];
            tx_d   = {8'h00, tx_q[22:0], tx_q[23]};
          end
        end else begin
          if (rd_valid_q) next_d = mem_rdata;
          if (sclk_fall) begin
            miso_d = tx_q[31];
            if (bit_cnt_q == 5'd31) begin
              tx_d      = next_q;
              bit_cnt_d = '0;
            end else begin
              tx_d      = {tx_q[30:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
            if (bit_cnt_q == 5'd16) begin
              mem_en_d   = 1'b1;
              mem_addr_d = mem_addr_q + ADDR_W'(1);
            end
          end
        end
      end
      IGNORE: begin
        miso_oe_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (cs_rise) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      tx_d      = '0;
      next_d    = '0;
      mem_en_d  = 1'b0;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
      busy_d    = 1'b0;
      rdid_d    = 1'b0;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      next_q     <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      rd_valid_q <= 1'b0;
      miso_q     <= 1'b0;
      miso_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      cmd_err_q  <= 1'b0;
      rdid_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      next_q     <= next_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      rd_valid_q <= rd_valid_d;
      miso_q     <= miso_d;
      miso_oe_q  <= miso_oe_d;
      busy_q     <= busy_d;
      cmd_err_q  <= cmd_err_d;
      rdid_q     <= rdid_d;
    end
  end

  assign miso     = miso_q;
  assign miso_oe  = miso_oe_q;
  assign mem_en   = mem_en_q;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
  assign cmd_err  = cmd_err_q;

endmodule
